// File: rtl/led_pkg.sv
// Shared constants for the LED serial driver and receiver.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package led_pkg;

  // Bits per frame sent by the LED driver.
  localparam int LED_FRAME_W = 16;

  // Edge polarity selector for edge detectors.
  typedef enum logic {
    EDGE_FALL = 1'b0,
    EDGE_RISE = 1'b1
  } edge_t;

  // led_clr clears the chain while low; led_pen latches on its rising edge.
  localparam logic  LED_CLR_ACTIVE     = 1'b0;
  localparam edge_t LED_PEN_LATCH_EDGE = EDGE_RISE;

  // Bit counter width: enough for WIDTH plus one spare bit, so over-length
  // frames stay distinguishable from full ones before saturating.
  function automatic int led_cnt_w(input int width);
    return $clog2(width + 1) + 1;
  endfunction

endpackage

// File: rtl/sync_edge.sv
// Synchroniser for one asynchronous line, with optional edge detector.
// Latency: STAGES clk to sync; edge pulse visible in the same cycle sync changes.
// Backpressure: none; free-running sampler.
module sync_edge
  import led_pkg::*;
#(
  parameter int    STAGES   = 2,
  parameter bit    EDGE_DET = 1'b1,
  parameter edge_t EDGE_POL = EDGE_RISE
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic sync,
  output logic rise
);

  logic [STAGES-1:0] chain;

  // Synchroniser chain, cleared on reset so idle lines read as 0.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) chain <= '0;
    else        chain <= {chain[STAGES-2:0], d};
  end

  assign sync = chain[STAGES-1];

  if (EDGE_DET) begin : g_edge
    logic dly;

    // One-cycle delay of the synchronised level for edge detection.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) dly <= 1'b0;
      else        dly <= sync;
    end

    assign rise = (EDGE_POL == EDGE_RISE) ? (sync & ~dly) : (~sync & dly);
  end else begin : g_no_edge
    assign rise = 1'b0;
  end

endmodule

// File: rtl/led_serial_rx.sv
// Deserialises the led_clk/led_do/led_clr/led_pen stream into a parallel word.
// Latency: valid pulses SYNC_STAGES+1 clk after the led_pen rising edge.
// Backpressure: none; each latched frame is presented once as a 1-clk valid pulse.
module led_serial_rx
  import led_pkg::*;
#(
  parameter int WIDTH       = LED_FRAME_W,
  parameter int SYNC_STAGES = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          led_clk,
  input  logic                          led_do,
  input  logic                          led_clr,
  input  logic                          led_pen,
  output logic [WIDTH-1:0]              data,
  output logic                          valid,
  output logic                          frame_err,
  output logic [led_cnt_w(WIDTH)-1:0]   bit_cnt
);

  localparam int               CNT_W    = led_cnt_w(WIDTH);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic             clk_sync_unused, pen_sync_unused;
  logic             do_rise_unused, clr_rise_unused;
  logic             clk_rise, pen_rise;
  logic             do_sync, clr_sync;
  logic             clr_act;
  logic [WIDTH-1:0] sr;
  logic [CNT_W-1:0] cnt_inc;

  sync_edge #(.STAGES(SYNC_STAGES), .EDGE_DET(1'b1), .EDGE_POL(EDGE_RISE)) u_clk (
    .clk(clk), .reset(reset), .d(led_clk), .sync(clk_sync_unused), .rise(clk_rise)
  );

  sync_edge #(.STAGES(SYNC_STAGES), .EDGE_DET(1'b1), .EDGE_POL(LED_PEN_LATCH_EDGE)) u_pen (
    .clk(clk), .reset(reset), .d(led_pen), .sync(pen_sync_unused), .rise(pen_rise)
  );

  sync_edge #(.STAGES(SYNC_STAGES), .EDGE_DET(1'b0)) u_do (
    .clk(clk), .reset(reset), .d(led_do), .sync(do_sync), .rise(do_rise_unused)
  );

  sync_edge #(.STAGES(SYNC_STAGES), .EDGE_DET(1'b0)) u_clr (
    .clk(clk), .reset(reset), .d(led_clr), .sync(clr_sync), .rise(clr_rise_unused)
  );

  assign clr_act = (clr_sync == LED_CLR_ACTIVE);
  assign cnt_inc = (bit_cnt == CNT_MAX) ? bit_cnt : bit_cnt + CNT_ONE;

  // Shift chain and output latch: clear beats latch beats shift. A latch in
  // the same cycle as a shift captures the pre-shift chain, then the new bit
  // becomes the first bit of the next frame.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sr        <= '0;
      data      <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
      bit_cnt   <= '0;
    end else begin
      valid <= 1'b0;
      if (clr_act) begin
        sr      <= '0;
        bit_cnt <= '0;
      end else begin
        if (pen_rise) begin
          data      <= sr;
          valid     <= 1'b1;
          frame_err <= (bit_cnt != CNT_FULL);
        end
        if (clk_rise) begin
          sr      <= {sr[WIDTH-2:0], do_sync};
          bit_cnt <= pen_rise ? CNT_ONE : cnt_inc;
        end else if (pen_rise) begin
          bit_cnt <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_led_serial_rx.sv
// Directed bench for led_serial_rx: framing, latency, clear, over/under-length
// frames, same-cycle latch+shift and reset behaviour.
// Drives and samples on the falling clk edge.
module tb_led_serial_rx;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        led_clk = 1'b0;
  logic        led_do = 1'b0;
  logic        led_clr = 1'b1;
  logic        led_pen = 1'b0;
  logic [15:0] data;
  logic        valid;
  logic        frame_err;
  logic [5:0]  bit_cnt;

  int passed = 0;
  int total  = 0;
  int vcount = 0;

  led_serial_rx #(.WIDTH(16), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset(reset), .led_clk(led_clk), .led_do(led_do),
    .led_clr(led_clr), .led_pen(led_pen), .data(data), .valid(valid),
    .frame_err(frame_err), .bit_cnt(bit_cnt)
  );

  always #5 clk = ~clk;

  // Count valid pulses seen by the bench.
  always @(negedge clk) if (valid === 1'b1) vcount++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    led_do = b;
    wait_n(2);
    led_clk = 1'b1;
    wait_n(3);
    led_clk = 1'b0;
    wait_n(3);
  endtask

  task automatic send_word(input logic [15:0] w, input int n);
    for (int i = n - 1; i >= 0; i--) send_bit(w[i]);
  endtask

  task automatic clr_pulse();
    led_clr = 1'b0;
    wait_n(4);
    led_clr = 1'b1;
    wait_n(4);
  endtask

  task automatic latch();
    led_pen = 1'b1;
    wait_n(4);
    led_pen = 1'b0;
    wait_n(4);
  endtask

  initial begin
    int v0;

    // Reset held while the lines toggle.
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      led_clk = ~led_clk;
      led_do  = ~led_do;
      led_pen = ~led_pen;
    end
    check("rst_data", data, 32'h0);
    check("rst_valid", valid, 32'h0);
    check("rst_ferr", frame_err, 32'h0);
    check("rst_cnt", bit_cnt, 32'h0);
    led_clk = 1'b0; led_pen = 1'b0; led_do = 1'b0; led_clr = 1'b0;
    wait_n(2);
    reset = 1'b1;
    wait_n(6);
    led_clr = 1'b1;
    wait_n(6);
    check("idle_vcount", vcount, 32'd0);
    check("idle_cnt", bit_cnt, 32'h0);

    // Basic 16-bit frame with latency check.
    clr_pulse();
    send_word(16'h0015, 16);
    check("f1_cnt", bit_cnt, 32'd16);
    led_pen = 1'b1;
    wait_n(2);
    check("f1_valid_c2", valid, 32'h0);
    wait_n(1);
    check("f1_valid_c3", valid, 32'h1);
    check("f1_data", data, 32'h0015);
    check("f1_ferr", frame_err, 32'h0);
    wait_n(1);
    check("f1_valid_c4", valid, 32'h0);
    check("f1_cnt_after", bit_cnt, 32'd0);
    led_pen = 1'b0;
    wait_n(4);

    // Loop-back style refreshes of 16'h001E.
    for (int r = 0; r < 3; r++) begin
      clr_pulse();
      send_word(16'h001E, 16);
      latch();
      check("loop_data", data, 32'h001E);
      check("loop_ferr", frame_err, 32'h0);
    end

    // Over-length frame: 18 bits then a proper frame.
    clr_pulse();
    send_word(16'h0003, 2);
    send_word(16'hA5A5, 16);
    check("ovr_cnt", bit_cnt, 32'd18);
    latch();
    check("ovr_data", data, 32'hA5A5);
    check("ovr_ferr", frame_err, 32'h1);
    send_word(16'h1234, 16);
    latch();
    check("ok_data", data, 32'h1234);
    check("ok_ferr", frame_err, 32'h0);

    // Clear mid-frame; edges while clear is low are ignored.
    clr_pulse();
    send_word(16'h0055, 7);
    check("mid_cnt7", bit_cnt, 32'd7);
    led_clr = 1'b0;
    wait_n(4);
    v0 = vcount;
    send_bit(1'b1);
    send_bit(1'b0);
    latch();
    check("clrlow_cnt", bit_cnt, 32'd0);
    check("clrlow_vcount", vcount - v0, 32'd0);
    check("clrlow_data", data, 32'h1234);
    led_clr = 1'b1;
    wait_n(4);
    send_word(16'hFFFF, 16);
    latch();
    check("clr_data", data, 32'hFFFF);
    check("clr_ferr", frame_err, 32'h0);

    // Same-cycle latch and shift.
    clr_pulse();
    send_word(16'h8001, 16);
    led_do = 1'b1;
    wait_n(2);
    v0 = vcount;
    led_clk = 1'b1;
    led_pen = 1'b1;
    wait_n(4);
    led_clk = 1'b0;
    led_pen = 1'b0;
    wait_n(4);
    check("same_data", data, 32'h8001);
    check("same_ferr", frame_err, 32'h0);
    check("same_cnt", bit_cnt, 32'd1);
    check("same_vcount", vcount - v0, 32'd1);
    // Latch again with one bit counted: exposes the shifted chain.
    latch();
    check("same_sr", data, 32'h0003);
    check("same_sr_ferr", frame_err, 32'h1);
    // Zero-bit latch: chain unchanged.
    latch();
    check("zero_data", data, 32'h0003);
    check("zero_ferr", frame_err, 32'h1);

    // Counter saturation.
    clr_pulse();
    for (int i = 0; i < 70; i++) send_bit(1'b1);
    check("sat_cnt", bit_cnt, 32'd63);
    latch();
    check("sat_data", data, 32'hFFFF);
    check("sat_ferr", frame_err, 32'h1);

    // Reset mid-frame discards everything at once.
    clr_pulse();
    send_word(16'h0015, 5);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("mrst_cnt", bit_cnt, 32'h0);
    check("mrst_data", data, 32'h0);
    check("mrst_ferr", frame_err, 32'h0);
    wait_n(3);
    reset = 1'b1;
    wait_n(6);
    check("mrst_valid", valid, 32'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
